hilo_mdu_sequencer: RTL and testbench

//  Multi-cycle multiply/divide sequencer that owns the HI/LO register pair.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_iter_core.sv | 39 +++
 rtl/hilo_mdu_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_hilo_mdu_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer:
// op codes, FSM state encoding and the default operand width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MADD  = 4'd3;
    localparam logic [3:0] OP_MSUB  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ITER  = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MADD) ||
               (op == OP_MSUB) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One combinational multiply/divide iteration step.
// Ports: DivMode selects restoring divide (1) or shift-add multiply (0);
// HiIn/LoIn are the accumulator halves, Operand the multiplicand/divisor;
// HiOut/LoOut the accumulator after one step.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             DivMode,
    input  logic [WIDTH-1:0] HiIn,
    input  logic [WIDTH-1:0] LoIn,
    input  logic [WIDTH-1:0] Operand,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        sum     = {1'b0, HiIn} + (LoIn[0] ? {1'b0, Operand} : '0);
        shifted = {HiIn, LoIn[WIDTH-1]};
        trial   = shifted - {1'b0, Operand};
        if (DivMode) begin
            // Remainder stays below the divisor, so bit WIDTH is the borrow.
            if (trial[WIDTH]) begin
                HiOut = shifted[WIDTH-1:0];
                LoOut = {LoIn[WIDTH-2:0], 1'b0};
            end else begin
                HiOut = trial[WIDTH-1:0];
                LoOut = {LoIn[WIDTH-2:0], 1'b1};
            end
        end else begin
            HiOut = sum[WIDTH:1];
            LoOut = {sum[0], LoIn[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// Ports: Clk, Reset (async, active-low); OpValid/OpCode/A/B request from EX;
// Flush squashes an in-flight op; HiLoRdReq flags mfhi/mflo in EX.
// OpReady/Busy/Stall/Done status; Hi/Lo registers; DivByZero flag.
// Build option: MDU_DIV_EN enables DIV/DIVU (restoring division).
module hilo_mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH           = MDU_WIDTH,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             OpValid,
    input  logic [3:0]       OpCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             HiLoRdReq,
    output logic             OpReady,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);

    localparam int N  = WIDTH / STEPS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [3:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
`ifdef MDU_DIV_EN
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic             dbz_q, dbz_d;
`endif

    logic             op_mul;
    logic             op_div;
    logic             sgn;
    logic             div_mode;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] hilo;

    logic [WIDTH-1:0] ch_hi [0:STEPS_PER_CYCLE];
    logic [WIDTH-1:0] ch_lo [0:STEPS_PER_CYCLE];

    assign ch_hi[0] = acc_hi_q;
    assign ch_lo[0] = acc_lo_q;

    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        mdu_iter_core #(.WIDTH(WIDTH)) u_core (
            .DivMode (div_mode),
            .HiIn    (ch_hi[g]),
            .LoIn    (ch_lo[g]),
            .Operand (opnd_q),
            .HiOut   (ch_hi[g+1]),
            .LoOut   (ch_lo[g+1])
        );
    end

`ifdef MDU_DIV_EN
    assign div_mode = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign op_div   = (OpCode == OP_DIV) || (OpCode == OP_DIVU);
`else
    assign div_mode = 1'b0;
    assign op_div   = 1'b0;
`endif

    assign op_mul = (OpCode == OP_MULT) || (OpCode == OP_MULTU) ||
                    (OpCode == OP_MADD) || (OpCode == OP_MSUB);
    assign sgn    = op_is_signed(OpCode);
    assign mag_a  = (sgn && A[WIDTH-1]) ? -A : A;
    assign mag_b  = (sgn && B[WIDTH-1]) ? -B : B;

    // Magnitude product with the sign applied, and current HI:LO.
    assign prod = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign hilo = {hi_q, lo_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MDU_DIV_EN
        negr_d   = negr_q;
        dz_d     = dz_q;
        dbz_d    = 1'b0;
`endif
        if (Flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (OpValid) begin
                        if (OpCode == OP_MTHI) begin
                            hi_d = A;
                        end else if (OpCode == OP_MTLO) begin
                            lo_d = A;
                        end else if (op_mul || op_div) begin
                            state_d  = ST_ITER;
                            cnt_d    = '0;
                            acc_hi_d = '0;
                            acc_lo_d = mag_a;
                            opnd_d   = mag_b;
                            op_d     = OpCode;
                            neg_d    = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef MDU_DIV_EN
                            negr_d   = sgn & A[WIDTH-1];
                            dz_d     = (B == '0);
`endif
                        end
                    end
                end
                ST_ITER: begin
                    acc_hi_d = ch_hi[STEPS_PER_CYCLE];
                    acc_lo_d = ch_lo[STEPS_PER_CYCLE];
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (op_q == OP_MADD) begin
                        {hi_d, lo_d} = hilo + prod;
                    end else if (op_q == OP_MSUB) begin
                        {hi_d, lo_d} = hilo - prod;
`ifdef MDU_DIV_EN
                    end else if (div_mode) begin
                        // Divide-by-zero keeps remainder = A, quotient forced to ones.
                        hi_d  = negr_q ? -acc_hi_q : acc_hi_q;
                        lo_d  = dz_q ? '1 :
                                (neg_q ? -acc_lo_q : acc_lo_q);
                        dbz_d = dz_q;
`endif
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            op_q     <= OP_NOP;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MDU_DIV_EN
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            dbz_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MDU_DIV_EN
            negr_q   <= negr_d;
            dz_q     <= dz_d;
            dbz_q    <= dbz_d;
`endif
        end
    end

    assign OpReady = (state_q == ST_IDLE);
    assign Busy    = (state_q == ST_ITER) || (state_q == ST_FINAL);
    assign Stall   = Busy & (OpValid | HiLoRdReq);
    assign Done    = done_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;
`ifdef MDU_DIV_EN
    assign DivByZero = dbz_q;
`else
    assign DivByZero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_mdu_sequencer.sv
// Directed testbench for hilo_mdu_sequencer.
// Divide scenarios depend on MDU_DIV_EN; otherwise DIV must act as NOP.
module tb_hilo_mdu_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        OpValid;
    logic [3:0]  OpCode;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        HiLoRdReq;
    logic        OpReady;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        DivByZero;

    int checks = 0;
    int errors = 0;

    hilo_mdu_sequencer #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .OpValid   (OpValid),
        .OpCode    (OpCode),
        .A         (A),
        .B         (B),
        .Flush     (Flush),
        .HiLoRdReq (HiLoRdReq),
        .OpReady   (OpReady),
        .Busy      (Busy),
        .Stall     (Stall),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge Clk);
        OpValid = 1'b1; OpCode = op; A = a; B = b;
        @(negedge Clk);
        OpValid = 1'b0; OpCode = 4'd0; A = '0; B = '0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (Done !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0; OpValid = 1'b0; OpCode = 4'd0; A = '0; B = '0;
        Flush = 1'b0; HiLoRdReq = 1'b0;
        #12;
        checks++;
        if ({Hi, Lo} !== 64'd0) begin
            errors++; $display("FAIL reset_hilo: got %h expected 0", {Hi, Lo});
        end
        checks++;
        if ({Busy, Done, DivByZero, OpReady, Stall} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_status: got %b expected 00010",
                     {Busy, Done, DivByZero, OpReady, Stall});
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_multu;
        int n;
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if ({Busy, OpReady} !== 2'b10) begin
            errors++; $display("FAIL multu_busy: got %b expected 10", {Busy, OpReady});
        end
        wait_done(n);
        checks++;
        if (n != 33) begin
            errors++; $display("FAIL multu_latency: got %0d expected 33", n);
        end
        checks++;
        if ({Hi, Lo} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL multu_result: got %h expected fffffffe00000001", {Hi, Lo});
        end
        @(negedge Clk);
        checks++;
        if ({Done, Busy} !== 2'b00) begin
            errors++; $display("FAIL multu_done_pulse: got %b expected 00", {Done, Busy});
        end
    endtask

    task automatic test_mult_madd;
        int n;
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        checks++;
        if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            errors++; $display("FAIL mult_neg: got %h expected fffffffffffffffa", {Hi, Lo});
        end
        issue(4'd3, 32'd2, 32'd3);
        wait_done(n);
        checks++;
        if ({Hi, Lo} !== 64'd0) begin
            errors++; $display("FAIL madd: got %h expected 0", {Hi, Lo});
        end
        issue(4'd4, 32'd4, 32'hFFFF_FFFB);
        wait_done(n);
        checks++;
        if ({Hi, Lo} !== 64'd20) begin
            errors++; $display("FAIL msub: got %h expected 14", {Hi, Lo});
        end
        issue(4'd2, 32'h0001_0000, 32'h0001_0000);
        wait_done(n);
        checks++;
        if ({Hi, Lo} !== 64'h0000_0001_0000_0000) begin
            errors++; $display("FAIL multu_carry: got %h expected 100000000", {Hi, Lo});
        end
        issue(4'd1, 32'h8000_0000, 32'h8000_0000);
        wait_done(n);
        checks++;
        if ({Hi, Lo} !== 64'h4000_0000_0000_0000) begin
            errors++;
            $display("FAIL mult_minint: got %h expected 4000000000000000", {Hi, Lo});
        end
    endtask

    task automatic test_mthi_hilord;
        int n;
        int bad;
        issue(4'd5, 32'h0000_1234, 32'd0);
        checks++;
        if ({Hi, Busy, Done} !== {32'h0000_1234, 2'b00}) begin
            errors++;
            $display("FAIL mthi: got hi=%h busy=%b done=%b expected 1234 0 0",
                     Hi, Busy, Done);
        end
        HiLoRdReq = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            errors++; $display("FAIL rd_idle_stall: got %b expected 0", Stall);
        end
        HiLoRdReq = 1'b0;
        issue(4'd6, 32'h0000_ABCD, 32'd0);
        checks++;
        if (Lo !== 32'h0000_ABCD) begin
            errors++; $display("FAIL mtlo: got %h expected abcd", Lo);
        end
        issue(4'd1, 32'd2, 32'd2);
        HiLoRdReq = 1'b1;
        n = 0; bad = 0;
        #1;
        while (Busy === 1'b1 && n < 100) begin
            if (Stall !== 1'b1) bad++;
            @(negedge Clk);
            n++;
        end
        checks++;
        if (bad != 0 || n != 33) begin
            errors++;
            $display("FAIL rd_busy_stall: got bad=%0d cycles=%0d expected 0 33", bad, n);
        end
        checks++;
        if ({Stall, Lo} !== {1'b0, 32'd4}) begin
            errors++; $display("FAIL rd_after: got stall=%b lo=%h expected 0 4", Stall, Lo);
        end
        HiLoRdReq = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n;
        int bad;
        issue(4'd1, 32'd7, 32'd9);
        OpValid = 1'b1; OpCode = 4'd2; A = 32'd6; B = 32'd7;
        n = 0; bad = 0;
        #1;
        while (OpReady !== 1'b1 && n < 100) begin
            if (Stall !== 1'b1) bad++;
            @(negedge Clk);
            n++;
        end
        checks++;
        if (bad != 0 || n != 33) begin
            errors++;
            $display("FAIL b2b_hold: got bad=%0d cycles=%0d expected 0 33", bad, n);
        end
        checks++;
        if ({Done, Lo} !== {1'b1, 32'd63}) begin
            errors++; $display("FAIL b2b_first: got done=%b lo=%h expected 1 3f", Done, Lo);
        end
        @(negedge Clk);
        OpValid = 1'b0; OpCode = 4'd0; A = '0; B = '0;
        checks++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: got busy=%b expected 1", Busy);
        end
        wait_done(n);
        checks++;
        if ({Hi, Lo} !== 64'd42) begin
            errors++; $display("FAIL b2b_second: got %h expected 2a", {Hi, Lo});
        end
    endtask

    task automatic test_flush;
        int seen;
        issue(4'd5, 32'd5, 32'd0);
        issue(4'd6, 32'd6, 32'd0);
        issue(4'd1, 32'd7, 32'd9);
        repeat (4) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        checks++;
        if ({Busy, OpReady, Hi, Lo} !== {2'b01, 32'd5, 32'd6}) begin
            errors++;
            $display("FAIL flush_idle: got busy=%b rdy=%b hi=%h lo=%h expected 0 1 5 6",
                     Busy, OpReady, Hi, Lo);
        end
        seen = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || {Hi, Lo} !== {32'd5, 32'd6}) begin
            errors++;
            $display("FAIL flush_nodone: got done_count=%0d hilo=%h expected 0 0000000500000006",
                     seen, {Hi, Lo});
        end
        @(negedge Clk);
        Flush = 1'b1; OpValid = 1'b1; OpCode = 4'd5; A = 32'h99;
        @(negedge Clk);
        Flush = 1'b0; OpValid = 1'b0; OpCode = 4'd0; A = '0;
        checks++;
        if (Hi !== 32'd5) begin
            errors++; $display("FAIL flush_beats_op: got hi=%h expected 5", Hi);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        int n;
        issue(4'd1, 32'd3, 32'd5);
        repeat (9) @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++;
        if ({Hi, Lo, Busy, OpReady, Done} !== {64'd0, 3'b010}) begin
            errors++;
            $display("FAIL reset_mid: got hilo=%h busy=%b rdy=%b done=%b expected 0 0 1 0",
                     {Hi, Lo}, Busy, OpReady, Done);
        end
        @(negedge Clk);
        Reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_mid_nodone: got %0d expected 0", seen);
        end
        issue(4'd1, 32'd3, 32'd5);
        wait_done(n);
        checks++;
        if ({Hi, Lo} !== 64'd15) begin
            errors++; $display("FAIL post_reset_mult: got %h expected f", {Hi, Lo});
        end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div;
        int n;
        issue(4'd7, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        checks++;
        if (n != 33 || {Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL div_signed: got lat=%0d hilo=%h expected 33 fffffffffffffffd",
                     n, {Hi, Lo});
        end
        issue(4'd8, 32'd100, 32'd7);
        wait_done(n);
        checks++;
        if ({Hi, Lo} !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL divu: got %h expected 000000020000000e", {Hi, Lo});
        end
        issue(4'd7, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        checks++;
        if ({Hi, Lo} !== 64'h0000_0000_8000_0000) begin
            errors++; $display("FAIL div_overflow: got %h expected 80000000", {Hi, Lo});
        end
        issue(4'd8, 32'd5, 32'd0);
        wait_done(n);
        checks++;
        if (n != 33 || {Hi, Lo, DivByZero} !== {32'd5, 32'hFFFF_FFFF, 1'b1}) begin
            errors++;
            $display("FAIL divu_zero: got lat=%0d hi=%h lo=%h dbz=%b expected 33 5 ffffffff 1",
                     n, Hi, Lo, DivByZero);
        end
        @(negedge Clk);
        checks++;
        if ({Done, DivByZero} !== 2'b00) begin
            errors++; $display("FAIL dbz_pulse: got %b expected 00", {Done, DivByZero});
        end
    endtask
`else
    task automatic test_div;
        int seen;
        issue(4'd7, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if ({Busy, OpReady} !== 2'b01) begin
            errors++; $display("FAIL div_nop_busy: got %b expected 01", {Busy, OpReady});
        end
        seen = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done === 1'b1 || DivByZero !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || {Hi, Lo} !== 64'd15) begin
            errors++;
            $display("FAIL div_nop: got events=%0d hilo=%h expected 0 f", seen, {Hi, Lo});
        end
    endtask
`endif

    initial begin
        test_reset;
        test_multu;
        test_mult_madd;
        test_mthi_hilord;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_div;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
